fetch_prefetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 17 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/fetch_prefetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch front end.
//   - fetch_state_t    : bus-side FSM states of fetch_prefetch_unit
//   - RESET_PC_DEFAULT : default first fetch address after reset
// ----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO holding {pc, instruction} entries for the fetch unit.
//   DEPTH must be a power of two so the pointers wrap naturally.
//   The storage is reset so the head reads as zero after reset.
//
// Ports
//   clk      : clock, all state on rising edge
//   reset    : synchronous active-high reset
//   i_push   : write i_wdata at the tail (caller guarantees space or a pop)
//   i_pop    : drop the head entry (ignored when empty)
//   i_clear  : empty the FIFO next edge; overrides push/pop
//   i_wdata  : entry to write
//   o_rdata  : head entry
//   o_full   : count == DEPTH
//   o_empty  : count == 0
//   o_count  : number of valid entries
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_prefetch_unit
//   Instruction-fetch front end. Issues sequential Wishbone classic reads
//   and buffers {pc, instruction} pairs in a prefetch FIFO that feeds decode
//   over a valid/ready handshake. Redirects flush the FIFO and restart fetch.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no bus cycle; issue one when the FIFO has room
//   ST_REQ     | read of fetch_pc outstanding; acked data is queued
//   ST_DISCARD | redirected while a read was outstanding; wait for its ack
//              | and drop the data
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   redirect_i          : flush queue, restart fetch at redirect_pc_i
//   redirect_pc_i       : new PC, byte-offset bits ignored
//   inst_valid_o        : queue head valid
//   inst_o, inst_pc_o   : head instruction and its PC
//   inst_ready_i        : decode accepts the head
//   wb_cyc_o, wb_stb_o  : bus cycle / strobe (always equal)
//   wb_ack_i            : slave acknowledge
//   wb_adr_o            : read address
//   wb_dat_o, wb_we_o   : tied to zero (read-only master)
//   wb_dat_i            : read data
//   wb_sel_o            : all ones while a cycle is active
// ----------------------------------------------------------------------------
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_i,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
  output logic                    inst_valid_o,
  output logic [DATA_WIDTH-1:0]   inst_o,
  output logic [ADDR_WIDTH-1:0]   inst_pc_o,
  input  logic                    inst_ready_i,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_we_o
);

  localparam int                    BYTES   = DATA_WIDTH / 8;
  localparam int                    CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int                    ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_INC  = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~(PC_INC - ADDR_WIDTH'(1));

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] w_fetch_pc_nxt;
  logic                  r_cyc;
  logic                  w_cyc_nxt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [ADDR_WIDTH-1:0] w_adr_nxt;

  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic [ADDR_WIDTH-1:0] w_pc_plus;
  logic                  w_push;
  logic                  w_fifo_push;
  logic                  w_pop;
  logic                  w_space;
  logic [CNT_W-1:0]      w_count_next;

  logic [ENTRY_W-1:0]    w_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;

  assign w_redirect_pc = redirect_pc_i & PC_MASK;
  assign w_pc_plus     = r_fetch_pc + PC_INC;

  // Only an ack for a live request (not being redirected away) is queued.
  assign w_push      = (r_state == ST_REQ) & wb_ack_i & ~redirect_i;
  // A request is only issued with room, so a full FIFO is pushed only
  // together with a pop; the gate keeps the FIFO safe regardless.
  assign w_fifo_push = w_push & (~w_fifo_full | w_pop);
  assign w_pop       = inst_valid_o & inst_ready_i;

  // Occupancy after this edge, used to decide whether another read fits.
  always_comb begin
    if (redirect_i) begin
      w_count_next = '0;
    end else begin
      w_count_next = w_fifo_count + CNT_W'(w_fifo_push) - CNT_W'(w_pop);
    end
  end

  assign w_space = (w_count_next < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_cyc      <= 1'b0;
      r_adr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_cyc      <= w_cyc_nxt;
      r_adr      <= w_adr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_cyc_nxt      = r_cyc;
    w_adr_nxt      = r_adr;
    unique case (r_state)
      ST_IDLE: begin
        if (redirect_i) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end else if (w_space) begin
          w_cyc_nxt   = 1'b1;
          w_adr_nxt   = r_fetch_pc;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          w_fetch_pc_nxt = w_redirect_pc;
          if (wb_ack_i) begin
            w_cyc_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            // The cycle cannot be abandoned; keep it open and drop its data.
            w_state_nxt = ST_DISCARD;
          end
        end else if (wb_ack_i) begin
          w_fetch_pc_nxt = w_pc_plus;
          if (w_space) begin
            w_adr_nxt = w_pc_plus;
          end else begin
            w_cyc_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (redirect_i) begin
          w_fetch_pc_nxt = w_redirect_pc;
        end
        if (wb_ack_i) begin
          w_cyc_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cyc_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_fifo_push),
    .i_pop   (w_pop),
    .i_clear (redirect_i),
    .i_wdata ({r_fetch_pc, wb_dat_i}),
    .o_rdata (w_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign inst_valid_o = ~w_fifo_empty;
  assign inst_o       = w_rdata[DATA_WIDTH-1:0];
  assign inst_pc_o    = w_rdata[ENTRY_W-1:DATA_WIDTH];

  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_adr_o = r_adr;
  assign wb_sel_o = {BYTES{r_cyc}};
  assign wb_dat_o = '0;
  assign wb_we_o  = 1'b0;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;

  fetch_prefetch_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (RST_PC),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i),
    .wb_cyc_o      (wb_cyc_o),
    .wb_stb_o      (wb_stb_o),
    .wb_ack_i      (wb_ack_i),
    .wb_adr_o      (wb_adr_o),
    .wb_dat_o      (wb_dat_o),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_o      (wb_sel_o),
    .wb_we_o       (wb_we_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } ent_t;

  // Reference model: in-order stream of fetched words plus the next PC.
  ent_t        q[$];
  logic [31:0] m_pc;
  logic        m_stale;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  // Slave model controls
  logic        slave_en;
  logic        rand_mode;
  int          s_lat;
  int          s_wait;
  logic [31:0] ack_log[$];

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    if (!reset) begin
      chk("bus_static", 64'({wb_stb_o, wb_sel_o, wb_we_o, wb_dat_o}),
          64'({wb_cyc_o, {4{wb_cyc_o}}, 1'b0, 32'h0}));
      chk("valid", 64'(inst_valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        h = q[0];
        chk("head", 64'({inst_pc_o, inst_o}), 64'({h.pc, h.dat}));
      end
      if (wb_cyc_o && !m_stale) chk("req_adr", 64'(wb_adr_o), 64'(m_pc));
      chk("occupancy", 64'(q.size() <= DEPTH), 64'(1));
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (reset) begin
      q.delete();
      m_pc    = RST_PC;
      m_stale = 1'b0;
    end else if (redirect_i) begin
      q.delete();
      m_stale = wb_cyc_o && !wb_ack_i;
      m_pc    = redirect_pc_i & ~32'h3;
    end else begin
      if (inst_ready_i && q.size() != 0) begin
        q.delete(0);
        n_pop++;
      end
      if (wb_cyc_o && wb_ack_i) begin
        if (m_stale) begin
          m_stale = 1'b0;
        end else begin
          e.pc  = m_pc;
          e.dat = fdat(m_pc);
          q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic tick();
    if (slave_en) begin
      if (wb_cyc_o) begin
        if (rand_mode) wb_ack_i = ($urandom_range(0, 2) != 0);
        else           wb_ack_i = (s_wait >= s_lat);
        if (wb_ack_i) s_wait = 0;
        else          s_wait++;
      end else begin
        wb_ack_i = 1'b0;
        s_wait   = 0;
      end
    end
    wb_dat_i = wb_ack_i ? fdat(wb_adr_o) : $urandom();
    if (wb_cyc_o && wb_ack_i) ack_log.push_back(wb_adr_o);
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ctl"}, 64'({inst_valid_o, wb_cyc_o, wb_stb_o, wb_sel_o, wb_we_o}), 64'(0));
    chk({tag, "_adr_dat"}, 64'({wb_adr_o, wb_dat_o}), 64'(0));
    chk({tag, "_head"}, 64'({inst_o, inst_pc_o}), 64'(0));
  endtask

  initial begin
    int t_start;
    reset         = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    inst_ready_i  = 1'b0;
    wb_ack_i      = 1'b0;
    wb_dat_i      = '0;
    slave_en      = 1'b0;
    rand_mode     = 1'b0;
    s_lat         = 1;
    s_wait        = 0;
    m_pc          = RST_PC;
    m_stale       = 1'b0;
    @(negedge clk);

    // Reset, release, four fetches with 1-wait slave and no consumer
    tick();
    tick();
    chk_reset_values("reset");
    slave_en = 1'b1;
    reset    = 1'b0;
    tick();
    chk("first_req", 64'({wb_cyc_o, wb_adr_o}), 64'({1'b1, RST_PC}));
    ack_log.delete();
    for (int i = 0; i < 40 && ack_log.size() < 4; i++) tick();
    chk("four_acks", 64'(ack_log.size()), 64'(4));
    if (ack_log.size() >= 4) begin
      chk("adr0", 64'(ack_log[0]), 64'(32'h8000_0000));
      chk("adr1", 64'(ack_log[1]), 64'(32'h8000_0004));
      chk("adr2", 64'(ack_log[2]), 64'(32'h8000_0008));
      chk("adr3", 64'(ack_log[3]), 64'(32'h8000_000C));
    end
    chk("full_cyc_drop", 64'(wb_cyc_o), 64'(0));
    chk("full_head", 64'({inst_valid_o, inst_pc_o}), 64'({1'b1, 32'h8000_0000}));

    // Full queue stays idle; one pop restarts fetch at the next word
    tick();
    tick();
    chk("full_idle", 64'(wb_cyc_o), 64'(0));
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    chk("refill_req", 64'({wb_cyc_o, wb_adr_o}), 64'({1'b1, 32'h8000_0010}));

    // Redirect while the read is outstanding, ack three cycles later
    slave_en      = 1'b0;
    wb_ack_i      = 1'b0;
    redirect_pc_i = 32'h8000_0100;
    redirect_i    = 1'b1;
    tick();
    redirect_i = 1'b0;
    chk("disc_hold0", 64'({wb_cyc_o, inst_valid_o}), 64'({1'b1, 1'b0}));
    tick();
    chk("disc_hold1", 64'(wb_cyc_o), 64'(1));
    tick();
    chk("disc_hold2", 64'(wb_cyc_o), 64'(1));
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("disc_drop", 64'({wb_cyc_o, inst_valid_o}), 64'(0));
    tick();
    chk("redir_req", 64'({wb_cyc_o, wb_adr_o}), 64'({1'b1, 32'h8000_0100}));

    // One accepted word, then redirect coinciding with ack (unaligned PC)
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("b2b_next", 64'({wb_cyc_o, inst_valid_o, wb_adr_o}), 64'({1'b1, 1'b1, 32'h8000_0104}));
    redirect_pc_i = 32'h8000_0103;
    redirect_i    = 1'b1;
    wb_ack_i      = 1'b1;
    tick();
    redirect_i = 1'b0;
    wb_ack_i   = 1'b0;
    chk("redir_ack_drop", 64'({wb_cyc_o, inst_valid_o}), 64'(0));
    tick();
    chk("redir_ack_req", 64'({wb_cyc_o, wb_adr_o}), 64'({1'b1, 32'h8000_0100}));

    // Streaming: 0-wait slave, consumer always ready, 64 words
    slave_en     = 1'b1;
    rand_mode    = 1'b0;
    s_lat        = 0;
    s_wait       = 0;
    inst_ready_i = 1'b1;
    n_pop        = 0;
    t_start      = 0;
    for (int i = 0; i < 300 && n_pop < 64; i++) begin
      tick();
      t_start++;
    end
    chk("stream_count", 64'(n_pop >= 64), 64'(1));
    chk("stream_rate", 64'(t_start <= 68), 64'(1));
    inst_ready_i = 1'b0;

    // Randomized traffic: random acks, ready and redirects (incl. wrap)
    rand_mode = 1'b1;
    n_pop     = 0;
    for (int i = 0; i < 3000; i++) begin
      inst_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc_i = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      else                           redirect_pc_i = 32'h8000_0000 + $urandom_range(0, 1023);
      tick();
    end
    redirect_i = 1'b0;
    chk("rand_progress", 64'(n_pop > 200), 64'(1));

    // Reset with a read outstanding, late ack right after release
    slave_en     = 1'b0;
    wb_ack_i     = 1'b0;
    inst_ready_i = 1'b1;
    for (int i = 0; i < 20 && !wb_cyc_o; i++) tick();
    chk("pre_reset_req", 64'(wb_cyc_o), 64'(1));
    reset = 1'b1;
    tick();
    chk_reset_values("mid_reset");
    reset    = 1'b0;
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("post_reset_req", 64'({wb_cyc_o, inst_valid_o, wb_adr_o}), 64'({1'b1, 1'b0, RST_PC}));
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
